// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a 5-digit common-anode
// seven-segment display with a one-cycle dark gap between digits and
// optional leading-zero blanking.
// Optional feature macro: SEVEN_SEG_SCANNER_BLINK_EN adds the blink port,
// the BLINK_DIV parameter and a frame counter that gates the whole display.
module seven_seg_scanner #(
  parameter int SCAN_DIV   = 50000,
`ifdef SEVEN_SEG_SCANNER_BLINK_EN
  parameter int BLINK_DIV  = 16,
`endif
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] tenthousands,
  input  logic [3:0] thousands,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       blank_zeros,
`ifdef SEVEN_SEG_SCANNER_BLINK_EN
  input  logic       blink,
`endif
  output logic [4:0] anode,
  output logic [6:0] segments
);

  localparam int             CW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(SCAN_DIV - 1);
  // Internal logic is active-low; these masks flip it for active-high panels.
  localparam logic [4:0]     INV_A   = {5{~ACTIVE_LOW}};
  localparam logic [6:0]     INV_S   = {7{~ACTIVE_LOW}};
  localparam logic [4:0]     OFF_A   = 5'b11111 ^ INV_A;
  localparam logic [6:0]     OFF_S   = 7'b1111111 ^ INV_S;

  typedef enum logic {S_LIT, S_GAP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      idx, idx_nxt;
  logic            frame_wrap;
  logic [4:0][3:0] shadow;
  logic [4:0]      dz;
  logic            blanked;
  logic            dark;
  logic [3:0]      cur_digit;

  // Active-low gfedcba pattern; non-BCD codes show a dash.
  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'b1000000;
      4'd1:    encode = 7'b1111001;
      4'd2:    encode = 7'b0100100;
      4'd3:    encode = 7'b0110000;
      4'd4:    encode = 7'b0011001;
      4'd5:    encode = 7'b0010010;
      4'd6:    encode = 7'b0000010;
      4'd7:    encode = 7'b1111000;
      4'd8:    encode = 7'b0000000;
      4'd9:    encode = 7'b0010000;
      default: encode = 7'b0111111;
    endcase
  endfunction

  // Shadow register: all five digits captured together on load.
  always_ff @(posedge clock) begin
    if (reset)     shadow <= '0;
    else if (load) shadow <= {tenthousands, thousands, hundreds, tens, ones};
  end

  // Scan state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_LIT;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Scan next-state: SCAN_DIV lit cycles, then one dark gap cycle that advances idx.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    frame_wrap = 1'b0;
    case (state)
      S_LIT: begin
        if (cnt == CNT_MAX) begin
          cnt_nxt   = '0;
          state_nxt = S_GAP;
        end else begin
          cnt_nxt   = cnt + CW'(1);
        end
      end
      S_GAP: begin
        state_nxt  = S_LIT;
        cnt_nxt    = '0;
        idx_nxt    = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        frame_wrap = (idx == 3'd4);
      end
    endcase
  end

`ifdef SEVEN_SEG_SCANNER_BLINK_EN
  localparam int FW = $clog2(BLINK_DIV + 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_DIV - 1);

  logic [FW-1:0] frame_cnt;
  logic          phase;

  // Frame counter: phase toggles every BLINK_DIV completed frames, runs regardless of blink.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_wrap) begin
      if (frame_cnt == FRM_MAX) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end
`endif

  // Leading-zero blanking and overall darkness for the digit being scanned.
  always_comb begin
    for (int k = 0; k < 5; k++) dz[k] = (shadow[k] == 4'd0);
    cur_digit = 4'd0;
    case (idx)
      3'd0: cur_digit = shadow[0];
      3'd1: cur_digit = shadow[1];
      3'd2: cur_digit = shadow[2];
      3'd3: cur_digit = shadow[3];
      3'd4: cur_digit = shadow[4];
      default: cur_digit = 4'd0;
    endcase
    blanked = 1'b0;
    case (idx)
      3'd1:    blanked = &dz[4:1];
      3'd2:    blanked = &dz[4:2];
      3'd3:    blanked = &dz[4:3];
      3'd4:    blanked = dz[4];
      default: blanked = 1'b0;
    endcase
    dark = (state == S_GAP) || (blank_zeros && blanked);
`ifdef SEVEN_SEG_SCANNER_BLINK_EN
    if (blink && phase) dark = 1'b1;
`endif
  end

  // Output register: one cycle behind the scan state, OFF while in reset.
  always_ff @(posedge clock) begin
    if (reset || dark) begin
      anode    <= OFF_A;
      segments <= OFF_S;
    end else begin
      anode    <= ~(5'b00001 << idx) ^ INV_A;
      segments <= encode(cur_digit) ^ INV_S;
    end
  end

endmodule
